// File: rtl/restoring_divider_8bit_if.sv
// Handshake and operand/result bundle for restoring_divider_8bit.
// The divider is the slave; whoever issues divisions is the master.
interface restoring_divider_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, all outputs registered.
// Optional DIV_ZERO_TRAP_EN: a zero divisor short-circuits to a 1-cycle flagged result.
module restoring_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  restoring_divider_8bit_if.slave  div_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

`ifdef DIV_ZERO_TRAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StZero} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   r_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   diff;
  logic             borrow8;
  logic             borrow_out;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Trial subtract: low byte with borrow, then borrow propagated through bit 8.
  always_comb begin
    s          = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff       = {1'b0, s[WIDTH-1:0]} - {1'b0, d_q};
    borrow8    = diff[WIDTH];
    borrow_out = borrow8 & ~s[WIDTH];
    t          = {s[WIDTH] ^ borrow8, diff[WIDTH-1:0]};
    r_nxt      = borrow_out ? s : t;
    q_nxt      = {q_q[WIDTH-2:0], ~borrow_out};
  end

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (div_io.start) begin
            d_q   <= div_io.divisor;
            q_q   <= div_io.dividend;
            r_q   <= '0;
            cnt_q <= '0;
`ifdef DIV_ZERO_TRAP_EN
            dbz_q <= 1'b0;
            if (div_io.divisor == '0) begin
              state_q <= StZero;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
`else
            state_q <= StRun;
            busy_q  <= 1'b1;
`endif
          end
        end
        StRun: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_nxt;
            rem_q   <= r_nxt[WIDTH-1:0];
          end
        end
`ifdef DIV_ZERO_TRAP_EN
        StZero: begin
          // q_q still holds the captured dividend here.
          state_q <= StIdle;
          done_q  <= 1'b1;
          dbz_q   <= 1'b1;
          quo_q   <= '1;
          rem_q   <= q_q;
        end
`endif
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_io.quotient  = quo_q;
  assign div_io.remainder = rem_q;
  assign div_io.busy      = busy_q;
  assign div_io.done      = done_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_io.div_by_zero = dbz_q;
`else
  assign div_io.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed plus randomized bench for restoring_divider_8bit; expectations come from plain / and %.
module tb_restoring_divider_8bit;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  restoring_divider_8bit_if #(.WIDTH(8)) bus ();

  restoring_divider_8bit #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
  endtask

  // Entered #1 after an edge, start_cyc edges after the accept edge; returns in the done cycle.
  task automatic wait_done(input int start_cyc, input logic [7:0] a, input logic [7:0] b,
                           input string tag);
    logic       zero_trap;
    logic [7:0] eq;
    logic [7:0] er;
    int         cyc;
    zero_trap = Trap && (b == 8'd0);
    eq  = (b == 8'd0) ? 8'hFF : a / b;
    er  = (b == 8'd0) ? a : a % b;
    cyc = start_cyc;
    while (bus.done !== 1'b1 && cyc < 20) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'(!zero_trap));
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), zero_trap ? 32'd1 : 32'd8);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(zero_trap));
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] eq;
    eq = (b == 8'd0) ? 8'hFF : a / b;
    accept(a, b);
    wait_done(0, a, b, tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_held_q"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    do_div(8'd200, 8'd7, "d200_7");
    do_div(8'd255, 8'd1, "d255_1");
    do_div(8'd5, 8'd9, "d5_9");
    do_div(8'd255, 8'd255, "d255_255");
    do_div(8'd77, 8'd0, "d77_0");

    // start pulsed mid-run must be ignored
    accept(8'd100, 8'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(3, 8'd100, 8'd3, "ignore");

    // start in the done cycle is accepted; old results held meanwhile
    accept(8'd50, 8'd5);
    chk("b2b_held_q", 32'(bus.quotient), 32'd33);
    chk("b2b_held_r", 32'(bus.remainder), 32'd1);
    chk("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done(0, 8'd50, 8'd5, "b2b");

    // reset mid-run aborts without done
    accept(8'd200, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_idle", 32'(bus.busy), 32'd0);
    end

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
